// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader_pkg
//  Purpose  : Shared types and defaults for the instruction-memory boot loader
//  Revision : 1.0  initial release
// ============================================================================
package inst_mem_loader_pkg;

  // Default instruction memory geometry
  localparam int WORDS_DEF = 64;
  localparam int AW_DEF    = 6;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // A word count is usable only if it is non-zero and fits the memory
  function automatic logic hdr_in_range(input logic [7:0] n, input logic [8:0] words);
    return (n != 8'd0) && ({1'b0, n} <= words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_byte_to_word_be.sv
`default_nettype none
// ============================================================================
//  Module   : byte_to_word_be
//  Purpose  : Assembles four bytes, first byte most significant, into a word
//             and flags the byte that completes it.
//  Revision : 1.0  initial release
// ============================================================================
module byte_to_word_be (
  input  logic        clk,
  input  logic        clrn,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // Shift the new byte in at the bottom so the first byte ends up in [31:24]
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Byte counter and word register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // The fourth byte of a word is being shifted in this cycle
  assign word_full = shift_en && !clear && (cnt_q == 2'd3);
  assign word      = word_q;

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader
//  Purpose  : Boot-time loader: consumes header/payload/checksum bytes,
//             writes big-endian words to instruction RAM and releases the
//             CPU from reset only after a load with a good checksum.
//  Revision : 1.0  initial release
// ============================================================================
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_resetn,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // Counts need one extra bit so that a full memory (N == WORDS) is representable
  localparam int         NW        = AW + 1;
  localparam logic [8:0] WORDS_LIM = 9'(WORDS);
  localparam logic [NW-1:0] IDX_ONE = NW'(1);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [NW-1:0] idx_inc;
  logic [7:0]    csum_q, csum_d;

  logic          byte_ready_q, byte_ready_d;
  logic          busy_q, busy_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cpu_resetn_q, cpu_resetn_d;

  logic          xfer;
  logic          asm_clear;
  logic          asm_shift;
  logic          asm_full;
  logic [31:0]   asm_word;

  assign xfer    = byte_valid && byte_ready_q;
  assign idx_inc = idx_q + IDX_ONE;

  // Word assembly lives in its own block; the loader only steers it
  byte_to_word_be u_asm (
    .clk       (clk),
    .clrn      (clrn),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_in),
    .word      (asm_word),
    .word_full (asm_full)
  );

  // Next-state, header latch, word index and running checksum
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HDR;
      end

      ST_HDR: begin
        if (xfer) begin
          if (hdr_in_range(byte_in, WORDS_LIM)) begin
            n_d       = NW'(byte_in);
            idx_d     = '0;
            csum_d    = 8'd0;
            asm_clear = 1'b1;
            state_d   = ST_DATA;
          end else begin
            state_d   = ST_ERR;
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          csum_d    = csum_q ^ byte_in;
          if (asm_full) state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // The write itself happens during this cycle; advance past it
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? ST_CSUM : ST_DATA;
      end

      ST_CSUM: begin
        if (xfer) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
      end

      ST_DONE, ST_ERR: begin
        if (start) state_d = ST_HDR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state so they line up with it
  always_comb begin
    byte_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    busy_d       = (state_d == ST_HDR) || (state_d == ST_DATA) ||
                   (state_d == ST_WRITE) || (state_d == ST_CSUM);
    we_d         = (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
    cpu_resetn_d = (state_d == ST_DONE);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      csum_q       <= 8'd0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      we_q         <= we_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_resetn_q <= cpu_resetn_d;
    end
  end

  // The index never exceeds WORDS-1 while WRITE is active, so the low bits suffice
  assign waddr      = idx_q[AW-1:0];
  assign wdata      = asm_word;
  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign we         = we_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_resetn = cpu_resetn_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Purpose  : Self-checking bench for inst_mem_loader
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_resetn;
  logic        busy;
  logic        done;
  logic        error;

  inst_mem_loader #(.WORDS(64), .AW(6)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_resetn (cpu_resetn),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write observed on the RAM port, as {addr, data}
  logic [37:0] got_q[$];

  always @(negedge clk) begin
    if (clrn && we) begin
      got_q.push_back({waddr, wdata});
      check("we_while_ready", {63'd0, byte_ready}, 64'd0);
    end
  end

  // Test records: stimulus knobs and the expected outcome
  typedef struct {
    int n;
    bit fixed;
    bit bad;
    int gap;
    bit exp_done;
    int exp_writes;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] fixed_pay[12];

  // Offer one byte, holding it until the loader takes it
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    waited     = 0;
    while (!byte_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) begin
      miscompares++;
      $display("FAIL byte_accept_timeout: got no byte_ready, expected byte_ready within 100 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",   {63'd0, busy},       64'd1);
    check("start_done",   {63'd0, done},       64'd0);
    check("start_error",  {63'd0, error},      64'd0);
    check("start_cpurst", {63'd0, cpu_resetn}, 64'd0);
  endtask

  // Run one complete load described by a record; the model derives writes from the bytes
  task automatic run_load(input vec_t v);
    logic [7:0]  pay[$];
    logic [37:0] exp_q[$];
    logic [7:0]  csum;
    bit          hdr_ok;
    int          waited;
    int          cnt;

    hdr_ok = (v.n >= 1) && (v.n <= 64);
    pay.delete();
    exp_q.delete();
    if (hdr_ok) begin
      for (int i = 0; i < v.n * 4; i++)
        pay.push_back(v.fixed ? fixed_pay[i % 12] : 8'($urandom));
      csum = 8'd0;
      foreach (pay[i]) csum = csum ^ pay[i];
      for (int w = 0; w < v.n; w++)
        exp_q.push_back({6'(w), pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]});
      if (v.bad) csum = csum ^ 8'h01;
    end else begin
      csum = 8'd0;
    end

    got_q.delete();
    pulse_start();
    send_byte(8'(v.n), v.gap > 0 ? $urandom_range(0, v.gap) : 0);
    if (hdr_ok) begin
      foreach (pay[i]) send_byte(pay[i], v.gap > 0 ? $urandom_range(0, v.gap) : 0);
      send_byte(csum, v.gap > 0 ? $urandom_range(0, v.gap) : 0);
    end

    waited = 0;
    while (!(done || error) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);

    check($sformatf("n%0d_done", v.n),   {63'd0, done},       {63'd0, v.exp_done});
    check($sformatf("n%0d_error", v.n),  {63'd0, error},      {63'd0, !v.exp_done});
    check($sformatf("n%0d_cpurst", v.n), {63'd0, cpu_resetn}, {63'd0, v.exp_done});
    check($sformatf("n%0d_busy", v.n),   {63'd0, busy},       64'd0);
    check($sformatf("n%0d_nwrites", v.n), 64'(got_q.size()), 64'(v.exp_writes));
    cnt = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < cnt; i++)
      check($sformatf("n%0d_write%0d", v.n, i), {26'd0, got_q[i]}, {26'd0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_we"},         {63'd0, we},         64'd0);
    check({tag, "_waddr"},      {58'd0, waddr},      64'd0);
    check({tag, "_wdata"},      {32'd0, wdata},      64'd0);
    check({tag, "_cpu_resetn"}, {63'd0, cpu_resetn}, 64'd0);
    check({tag, "_busy"},       {63'd0, busy},       64'd0);
    check({tag, "_done"},       {63'd0, done},       64'd0);
    check({tag, "_error"},      {63'd0, error},      64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fixed_pay = '{8'h3C, 8'h03, 8'hC0, 8'h00,
                  8'h20, 8'h05, 8'h00, 8'h00,
                  8'h0C, 8'h00, 8'h00, 8'h07};
    //          n    fixed bad gap done writes
    vecs[0] = '{3,   1'b1, 1'b0, 0, 1'b1, 3};
    vecs[1] = '{3,   1'b1, 1'b0, 4, 1'b1, 3};
    vecs[2] = '{3,   1'b1, 1'b1, 0, 1'b0, 3};
    vecs[3] = '{3,   1'b1, 1'b0, 2, 1'b1, 3};
    vecs[4] = '{0,   1'b0, 1'b0, 0, 1'b0, 0};
    vecs[5] = '{65,  1'b0, 1'b0, 0, 1'b0, 0};
    vecs[6] = '{64,  1'b0, 1'b0, 0, 1'b1, 64};
    vecs[7] = '{1,   1'b0, 1'b0, 3, 1'b1, 1};
    vecs[8] = '{200, 1'b0, 1'b0, 0, 1'b0, 0};
    vecs[9] = '{17,  1'b0, 1'b1, 3, 1'b0, 17};

    clrn       = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    clrn = 1'b1;
    @(negedge clk);

    // Idle with a byte on offer but no start: nothing may be consumed or written
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_byte_ready", {63'd0, byte_ready}, 64'd0);
      check("idle_we",         {63'd0, we},         64'd0);
    end
    byte_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_load(vecs[i]);

    // Reset in the middle of a load: one word out, then clrn drops between edges
    got_q.delete();
    pulse_start();
    send_byte(8'd3, 0);
    for (int i = 0; i < 6; i++) send_byte(fixed_pay[i], 1);
    check("midrst_nwrites", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("midrst_addr", {58'd0, got_q[0][37:32]}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd1);
    #2 clrn = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    run_load(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
